multicycle_controller: RTL and testbench

Control sequencer for the multi-cycle variant of the RV32I core. It steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables: program counter, instruction register, register file, data memory, ALU selects and write-back mux. It handshakes with instruction and data memories that may take several cycles, and keeps a retired-instruction counter.

---
 rtl/multicycle_controller.sv | 171 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control sequencer: steps FETCH/DECODE/EXEC/MEM/WB, drives datapath
// enables, handshakes with variable-latency memories and counts retired instructions.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StIdle   = 3'd5,
        StHalt   = 3'd7
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    state_e      r_state;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic        r_illegal;
    logic [31:0] r_instret;

    logic w_is_r;
    logic w_is_i;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_br;
    logic w_is_bne;
    logic w_is_legal;
    logic w_unused_instr;

    // Only opcode and funct3 steer the sequence; the rest belongs to the datapath.
    assign w_unused_instr = ^{instr[31:15], instr[11:7]};

    // Instruction class decode from the latched opcode/funct3
    always_comb begin
        w_is_r     = (r_opcode == OpR);
        w_is_i     = (r_opcode == OpI);
        w_is_lw    = (r_opcode == OpLoad)  && (r_funct3 == 3'b010);
        w_is_sw    = (r_opcode == OpStore) && (r_funct3 == 3'b010);
        w_is_br    = (r_opcode == OpBranch) && (r_funct3[2:1] == 2'b00);
        w_is_bne   = r_funct3[0];
        w_is_legal = w_is_r || w_is_i || w_is_lw || w_is_sw || w_is_br;
    end

    // Output decode: state-driven, with the three combinational handshake/flag paths
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = AluAdd;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        unique case (r_state)
            StFetch: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            StExec: begin
                alu_src = w_is_i || w_is_lw || w_is_sw;
                if (w_is_br) begin
                    alu_op   = AluSub;
                    pc_write = 1'b1;
                    pc_sel   = w_is_bne ? ~zero : zero;
                end else if (w_is_r || w_is_i) begin
                    alu_op = AluFunct;
                end
            end
            StMem: begin
                dmem_read  = w_is_lw;
                dmem_write = w_is_sw;
                pc_write   = w_is_sw && dmem_ready;
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = w_is_lw;
                pc_write   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_opcode  <= 7'd0;
            r_funct3  <= 3'd0;
            r_illegal <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            if (ir_write) begin
                r_opcode <= instr[6:0];
                r_funct3 <= instr[14:12];
            end
            if (pc_write) begin
                r_instret <= r_instret + 32'd1;
            end
            case (r_state)
                StIdle: r_state <= StFetch;
                StFetch: begin
                    if (imem_ready) begin
                        r_state <= StDecode;
                    end
                end
                StDecode: begin
                    if (w_is_legal) begin
                        r_state <= StExec;
                    end else begin
                        r_state   <= StHalt;
                        r_illegal <= 1'b1;
                    end
                end
                StExec: begin
                    if (w_is_br) begin
                        r_state <= StFetch;
                    end else if (w_is_lw || w_is_sw) begin
                        r_state <= StMem;
                    end else begin
                        r_state <= StWb;
                    end
                end
                StMem: begin
                    if (dmem_ready) begin
                        r_state <= w_is_lw ? StWb : StFetch;
                    end
                end
                StWb:    r_state <= StFetch;
                StHalt:  r_state <= StHalt;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign illegal = r_illegal;
    assign state   = r_state;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: each instruction is expanded into its expected per-cycle
// output trace from the class rules; a negedge process compares the DUT against that trace.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        imem_req, ir_write, pc_write, pc_sel, alu_src;
    logic [1:0]  alu_op;
    logic        dmem_read, dmem_write, reg_write, mem_to_reg, illegal;
    logic [2:0]  state;
    logic [31:0] instret;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .zero       (zero),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .state      (state),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic       pc_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       dmem_read;
        logic       dmem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
    } exp_t;

    localparam int CR = 0, CI = 1, CLW = 2, CSW = 3, CBEQ = 4, CBNE = 5, CILL = 6;

    exp_t        exp_cur;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_instret;
    logic [31:0] model_instret = 32'd0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_count = 0;
    logic [14:0] got;

    assign got = {state, imem_req, ir_write, pc_write, pc_sel, alu_src, alu_op,
                  dmem_read, dmem_write, reg_write, mem_to_reg, illegal};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("outputs", {17'd0, got}, {17'd0, exp_cur});
            chk("instret", instret, exp_instret);
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic int classify(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0110011: return CR;
            7'b0010011: return CI;
            7'b0000011: return (f3 == 3'b010) ? CLW : CILL;
            7'b0100011: return (f3 == 3'b010) ? CSW : CILL;
            7'b1100011: return (f3 == 3'b000) ? CBEQ : (f3 == 3'b001) ? CBNE : CILL;
            default:    return CILL;
        endcase
    endfunction

    function automatic logic [31:0] make_instr(input int cls);
        logic [31:0] ins;
        ins = $urandom;
        case (cls)
            CR:   ins[6:0] = 7'b0110011;
            CI:   ins[6:0] = 7'b0010011;
            CLW:  begin ins[6:0] = 7'b0000011; ins[14:12] = 3'b010; end
            CSW:  begin ins[6:0] = 7'b0100011; ins[14:12] = 3'b010; end
            CBEQ: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b000; end
            CBNE: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b001; end
            default: begin
                if (rb()) begin
                    ins[6:0]   = 7'b0000011;
                    ins[14:12] = 3'b000;
                end else begin
                    ins[6:0] = 7'b1111111;
                end
            end
        endcase
        return ins;
    endfunction

    // One clock cycle: drive inputs, publish expectation, advance past the edge.
    task automatic cyc(input exp_t e, input logic ir, input logic dr, input logic z,
                       input logic [31:0] ins);
        imem_ready  = ir;
        dmem_ready  = dr;
        zero        = z;
        instr       = ins;
        exp_cur     = e;
        exp_instret = model_instret;
        exp_valid   = 1'b1;
        @(posedge clk);
        #1;
        if (e.pc_write) model_instret = model_instret + 32'd1;
        cyc_count++;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic z,
                             input int halt_cycles, input int abort_mem, output int ncyc);
        int   cls;
        int   start;
        exp_t e;
        cls   = classify(ins);
        start = cyc_count;
        for (int k = 0; k < wf; k++) begin
            e = blank(3'd0);
            e.imem_req = 1'b1;
            cyc(e, 1'b0, rb(), rb(), $urandom);
        end
        e = blank(3'd0);
        e.imem_req = 1'b1;
        e.ir_write = 1'b1;
        cyc(e, 1'b1, rb(), rb(), ins);
        cyc(blank(3'd1), rb(), rb(), rb(), $urandom);
        if (cls == CILL) begin
            for (int k = 0; k < halt_cycles; k++) begin
                e = blank(3'd7);
                e.illegal = 1'b1;
                cyc(e, rb(), rb(), rb(), $urandom);
            end
            ncyc = cyc_count - start;
            return;
        end
        e = blank(3'd2);
        e.alu_src = (cls == CI) || (cls == CLW) || (cls == CSW);
        if (cls == CLW || cls == CSW)       e.alu_op = 2'b00;
        else if (cls == CBEQ || cls == CBNE) e.alu_op = 2'b01;
        else                                 e.alu_op = 2'b10;
        if (cls == CBEQ || cls == CBNE) begin
            e.pc_write = 1'b1;
            e.pc_sel   = (cls == CBEQ) ? z : ~z;
        end
        cyc(e, rb(), rb(), z, $urandom);
        if (cls == CLW || cls == CSW) begin
            for (int k = 0; k < wm; k++) begin
                if (abort_mem != 0 && k == abort_mem) begin
                    ncyc = cyc_count - start;
                    return;
                end
                e = blank(3'd3);
                e.dmem_read  = (cls == CLW);
                e.dmem_write = (cls == CSW);
                cyc(e, rb(), 1'b0, rb(), $urandom);
            end
            e = blank(3'd3);
            e.dmem_read  = (cls == CLW);
            e.dmem_write = (cls == CSW);
            e.pc_write   = (cls == CSW);
            cyc(e, rb(), 1'b1, rb(), $urandom);
        end
        if (cls == CR || cls == CI || cls == CLW) begin
            e = blank(3'd4);
            e.reg_write  = 1'b1;
            e.mem_to_reg = (cls == CLW);
            e.pc_write   = 1'b1;
            cyc(e, rb(), rb(), rb(), $urandom);
        end
        ncyc = cyc_count - start;
    endtask

    // Asynchronous reset mid-cycle, literal checks, then release and the IDLE cycle.
    task automatic do_reset();
        exp_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_state", {29'd0, state}, 32'd5);
        chk("rst_strobes", {20'd0, got[11:0]}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_instret = 32'd0;
        cyc(blank(3'd5), rb(), rb(), rb(), $urandom);
    endtask

    initial begin
        int n;
        int cls;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run_instr(32'h002081B3, 0, 0, 1'b0, 0, 0, n);
        chk("r_cycles", n, 4);
        chk("r_instret", instret, 1);
        run_instr(32'h0000A183, 0, 3, 1'b0, 0, 0, n);
        chk("lw_wait_cycles", n, 8);
        run_instr(32'h00208463, 0, 0, 1'b1, 0, 0, n);
        chk("beq_cycles", n, 3);
        run_instr(32'h00208463, 0, 0, 1'b0, 0, 0, n);
        run_instr(32'h00209463, 0, 0, 1'b0, 0, 0, n);
        run_instr(32'h0020A023, 0, 0, 1'b0, 0, 0, n);
        chk("sw_cycles", n, 4);
        run_instr(32'h0000A183, 0, 0, 1'b0, 0, 0, n);
        chk("lw_cycles", n, 5);
        chk("instret_after_seq", instret, 7);

        run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 20, 0, n);
        chk("halt_state", {29'd0, state}, 32'd7);
        chk("halt_illegal", {31'd0, illegal}, 32'd1);
        do_reset();
        chk("illegal_cleared", {31'd0, illegal}, 32'd0);

        run_instr(32'h002081B3, 1, 0, 1'b0, 0, 0, n);
        run_instr(32'h0000A183, 0, 5, 1'b0, 0, 2, n);
        do_reset();
        run_instr(32'h002081B3, 0, 0, 1'b0, 0, 0, n);
        chk("after_abort_instret", instret, 1);

        for (int i = 0; i < 300; i++) begin
            cls = (($urandom_range(0, 9) == 0) ? CILL : int'($urandom_range(0, 5)));
            run_instr(make_instr(cls), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      rb(), 3, 0, n);
            if (cls == CILL) do_reset();
        end

        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
